// File: rtl/wave_capture.sv
// wave_capture: double-buffered waveform capture for a column display.
// A frame of DEPTH samples is written into the back bank while the display
// reads the front bank; the banks swap on the edge that writes the last
// sample, so readers only ever see complete frames.
//
// Optional feature: define WAVE_CAPTURE_TRIGGER_EN to start frames on a rising
// crossing of TRIG_LEVEL; otherwise a frame starts on the first sample once armed.
//
// Ports:
//   CLOCK, RESETN          clock, async active-low reset
//   sample_valid/sample_in sample strobe and data
//   freeze                 blocks the start of new frames while high
//   rd_en/rd_addr          display read request and column
//   rd_data/rd_valid       read result, one cycle after rd_en
//   capture_done           one-cycle pulse per completed frame
//   frame_count            completed frame counter (wraps)
module wave_capture #(
    parameter int unsigned DEPTH      = 640,
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned TRIG_LEVEL = 512
) (
    input  logic             CLOCK,
    input  logic             RESETN,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             freeze,
    input  logic             rd_en,
    input  logic [9:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             capture_done,
    output logic [7:0]       frame_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
`ifdef WAVE_CAPTURE_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_wr_addr;
    logic             w_wr_en;
    logic             w_swap;
    logic             r_bank_sel;      // index of the front bank
    logic [WIDTH-1:0] r_prev_sample;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_capture_done;
    logic [7:0]       r_frame_count;
    logic             w_edge;
    logic             w_trig;
    logic             w_rd_in_range;
    logic [AW-1:0]    w_rd_idx;
    logic [WIDTH-1:0] w_front_word;

    logic [WIDTH-1:0] r_bank0 [DEPTH];
    logic [WIDTH-1:0] r_bank1 [DEPTH];

    // Trigger: rising crossing of the threshold, or any sample when disabled
    assign w_edge = (r_prev_sample < WIDTH'(TRIG_LEVEL)) && (sample_in >= WIDTH'(TRIG_LEVEL));
    assign w_trig = sample_valid && (!TRIG_EN || w_edge);

    // Next-state and write control
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_wr_addr    = r_wr_ptr;
        w_wr_en      = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!freeze) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (!freeze && w_trig) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = '0;
                    w_wr_ptr_nxt = AW'(1);
                    w_state_nxt  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wr_ptr == LAST_PTR) begin
                        w_swap       = 1'b1;
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = HOLD;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                    end
                end
            end
            HOLD: begin
                if (!freeze) w_state_nxt = ARMED;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Front-bank read mux; out-of-range columns read as zero
    assign w_rd_in_range = 32'(rd_addr) < DEPTH;
    assign w_rd_idx      = AW'(rd_addr);
    assign w_front_word  = r_bank_sel ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

    // Control and output registers
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            r_state        <= IDLE;
            r_wr_ptr       <= '0;
            r_bank_sel     <= 1'b0;
            r_prev_sample  <= '0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_capture_done <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_bank_sel     <= r_bank_sel ^ w_swap;
            r_capture_done <= w_swap;
            r_rd_valid     <= rd_en;
            if (w_swap) r_frame_count <= r_frame_count + 8'd1;
            if (sample_valid) r_prev_sample <= sample_in;
            if (rd_en) r_rd_data <= w_rd_in_range ? w_front_word : '0;
        end
    end

    // Sample RAM: writes always target the back bank, contents are not reset
    always_ff @(posedge CLOCK) begin
        if (w_wr_en) begin
            if (r_bank_sel) r_bank0[w_wr_addr] <= sample_in;
            else            r_bank1[w_wr_addr] <= sample_in;
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign capture_done = r_capture_done;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: a frame-level model (queues of samples) is checked
// against the DUT every clock, plus hand-computed literal expectations.
module tb_wave_capture;

    localparam int DEPTH      = 640;
    localparam int TRIG_LEVEL = 512;

    logic       CLOCK        = 1'b0;
    logic       RESETN       = 1'b0;
    logic       sample_valid = 1'b0;
    logic [9:0] sample_in    = '0;
    logic       freeze       = 1'b0;
    logic       rd_en        = 1'b0;
    logic [9:0] rd_addr      = '0;
    logic [9:0] rd_data;
    logic       rd_valid;
    logic       capture_done;
    logic [7:0] frame_count;

    wave_capture #(.DEPTH(640), .WIDTH(10), .TRIG_LEVEL(512)) dut (
        .CLOCK        (CLOCK),
        .RESETN       (RESETN),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .freeze       (freeze),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .capture_done (capture_done),
        .frame_count  (frame_count)
    );

    always #5 CLOCK = ~CLOCK;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    // Frame-level model
    int m_front[DEPTH];
    int m_cur[$];
    bit m_front_known;
    bit m_waiting;     // needs freeze low before it may arm
    bit m_armed;       // looking for a start sample
    int m_prev;
    int m_count;
    int m_exp_data;
    bit m_exp_known;
    bit m_exp_valid;
    bit m_exp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit starts_frame(input int prev, input int cur);
`ifdef WAVE_CAPTURE_TRIGGER_EN
        return (prev < TRIG_LEVEL) && (cur >= TRIG_LEVEL);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_cur.delete();
        m_front_known = 1'b0;
        m_waiting     = 1'b1;
        m_armed       = 1'b0;
        m_prev        = 0;
        m_count       = 0;
        m_exp_data    = 0;
        m_exp_known   = 1'b1;
        m_exp_valid   = 1'b0;
        m_exp_done    = 1'b0;
    endfunction

    function automatic void model_step(input bit sv, input int si, input bit fr, input bit re, input int ra);
        m_exp_valid = re;
        if (re) begin
            if (ra >= DEPTH) begin
                m_exp_data  = 0;
                m_exp_known = 1'b1;
            end else begin
                m_exp_data  = m_front[ra];
                m_exp_known = m_front_known;
            end
        end
        m_exp_done = 1'b0;
        if (m_cur.size() > 0) begin
            if (sv) begin
                m_cur.push_back(si);
                if (m_cur.size() == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) m_front[i] = m_cur[i];
                    m_front_known = 1'b1;
                    m_cur.delete();
                    m_exp_done = 1'b1;
                    m_count    = (m_count + 1) % 256;
                    m_waiting  = 1'b1;
                end
            end
        end else if (m_armed) begin
            if (!fr && sv && starts_frame(m_prev, si)) begin
                m_cur.push_back(si);
                m_armed = 1'b0;
            end
        end else if (m_waiting) begin
            if (!fr) begin
                m_waiting = 1'b0;
                m_armed   = 1'b1;
            end
        end
        if (sv) m_prev = si;
    endfunction

    // Per-cycle compare against the model
    always @(posedge CLOCK) begin
        bit c_sv, c_fr, c_re;
        int c_si, c_ra;
        c_sv = sample_valid;
        c_fr = freeze;
        c_re = rd_en;
        c_si = int'(sample_in);
        c_ra = int'(rd_addr);
        if (!RESETN) model_reset();
        else         model_step(c_sv, c_si, c_fr, c_re, c_ra);
        #1;
        check("cyc_rd_valid", 32'(rd_valid), 32'(m_exp_valid));
        check("cyc_capture_done", 32'(capture_done), 32'(m_exp_done));
        check("cyc_frame_count", 32'(frame_count), 32'(m_count));
        if (m_exp_known) check("cyc_rd_data", 32'(rd_data), 32'(m_exp_data));
        if (capture_done === 1'b1) n_done++;
    end

    task automatic send(input int v);
        sample_valid = 1'b1;
        sample_in    = 10'(v);
        @(negedge CLOCK);
        sample_valid = 1'b0;
    endtask

    task automatic rd(input int a, input int exp, input string nm);
        rd_en   = 1'b1;
        rd_addr = 10'(a);
        @(negedge CLOCK);
        rd_en = 1'b0;
        check({nm, "_valid"}, 32'(rd_valid), 32'd1);
        check(nm, 32'(rd_data), 32'(exp));
        @(negedge CLOCK);
        check({nm, "_idle_valid"}, 32'(rd_valid), 32'd0);
        check({nm, "_hold"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int nsamp;
        int old5;
`ifdef WAVE_CAPTURE_TRIGGER_EN
        nsamp = 1152;
        old5  = 517;
`else
        nsamp = 640;
        old5  = 5;
`endif
        // Reset state
        repeat (3) @(negedge CLOCK);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_capture_done", 32'(capture_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        RESETN = 1'b1;
        repeat (3) @(negedge CLOCK);

        // Frame 1: ramp, one strobe per four clocks
        for (int k = 0; k < nsamp; k++) begin
            send(k % 1024);
            if (k == nsamp - 1) check("f1_done_pulse", 32'(capture_done), 32'd1);
            repeat (3) @(negedge CLOCK);
        end
        check("f1_done_count", 32'(n_done), 32'd1);
        check("f1_frame_count", 32'(frame_count), 32'd1);
`ifdef WAVE_CAPTURE_TRIGGER_EN
        rd(0, 512, "f1_rd0");
        rd(511, 1023, "f1_rd511");
        rd(639, 127, "f1_rd639");
`else
        rd(100, 100, "f1_rd100");
        rd(0, 0, "f1_rd0");
        rd(639, 639, "f1_rd639");
`endif

        // Frame 2: read column 5 continuously across the swap
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 630) begin
                rd_en   = 1'b1;
                rd_addr = 10'd5;
            end
            send(700 + k);
            if (k == DEPTH - 1) begin
                check("swap_done", 32'(capture_done), 32'd1);
                check("swap_old", 32'(rd_data), 32'(old5));
                @(negedge CLOCK);
                check("swap_new", 32'(rd_data), 32'd705);
                rd_en = 1'b0;
            end
            repeat (3) @(negedge CLOCK);
        end
        check("f2_frame_count", 32'(frame_count), 32'd2);

        // Frame 3: freeze rises mid-capture, frame still completes
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 100) freeze = 1'b1;
            send(900 + k);
            if (k == DEPTH - 1) check("frz_done", 32'(capture_done), 32'd1);
            repeat (3) @(negedge CLOCK);
        end
        check("frz_frame_count", 32'(frame_count), 32'd3);
        for (int k = 0; k < 2000; k++) begin
            send(k % 512);
            @(negedge CLOCK);
        end
        check("frz_hold_count", 32'(frame_count), 32'd3);
        check("frz_done_total", 32'(n_done), 32'd3);
        rd(0, 900, "frz_rd0");
        rd(5, 905, "frz_rd5");
        rd(639, 515, "frz_rd639");
        rd(700, 0, "oor_rd700");

        // Frame 4: reset asynchronously after 300 samples
        freeze = 1'b0;
        repeat (2) @(negedge CLOCK);
        for (int k = 0; k < 300; k++) begin
            send(600 + k);
            repeat (3) @(negedge CLOCK);
        end
        rd_en   = 1'b1;
        rd_addr = 10'd5;
        @(posedge CLOCK);
        #1;
        check("pre_rst_valid", 32'(rd_valid), 32'd1);
        check("pre_rst_data", 32'(rd_data), 32'd905);
        #1;
        RESETN = 1'b0;
        #1;
        check("arst_rd_data", 32'(rd_data), 32'd0);
        check("arst_rd_valid", 32'(rd_valid), 32'd0);
        check("arst_capture_done", 32'(capture_done), 32'd0);
        check("arst_frame_count", 32'(frame_count), 32'd0);
        rd_en = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESETN = 1'b1;
        repeat (3) @(negedge CLOCK);

        // Frame 5: capture restarts from column 0
        for (int k = 0; k < DEPTH; k++) begin
            send(550 + k);
            if (k == DEPTH - 1) check("post_rst_done", 32'(capture_done), 32'd1);
            repeat (3) @(negedge CLOCK);
        end
        check("post_rst_frame_count", 32'(frame_count), 32'd1);
        rd(0, 550, "post_rst_rd0");
        rd(299, 849, "post_rst_rd299");
        rd(639, 165, "post_rst_rd639");

        repeat (2) @(negedge CLOCK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
